// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: drives one external 1-bit ALU slice from LSB to MSB,
// closing the carry ripple through a register and reporting result and flags.
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             overflow,
  output logic             zero,
  output logic             err,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_control,
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       ctrl_r;
  logic             carry_r;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] out_next_s;
  logic             carryout_r;
  logic             overflow_r;
  logic             zero_r;
  logic             err_r;
  logic             busy_r;
  logic             done_r;
  logic             illegal_s;
  logic             arith_s;
  logic             last_s;

  // Opcodes 0 and 1 have no slice meaning; bit 2 clear marks add/sub.
  assign illegal_s = (control[2:1] == 2'b00);
  assign arith_s   = ~ctrl_r[2];
  assign last_s    = (idx_r == IW'(WIDTH - 1));

  assign busy     = busy_r;
  assign done     = done_r;
  assign out      = out_r;
  assign carryout = carryout_r;
  assign overflow = overflow_r;
  assign zero     = zero_r;
  assign err      = err_r;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = illegal_s ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Slice drive: only the current bit in RUN, quiet otherwise.
  always_comb begin
    slice_a       = 1'b0;
    slice_b       = 1'b0;
    slice_cin     = 1'b0;
    slice_control = 3'h0;
    if (state_r == RUN) begin
      slice_a       = a_r[idx_r];
      slice_b       = b_r[idx_r];
      slice_cin     = arith_s ? carry_r : 1'b0;
      slice_control = ctrl_r;
    end else begin
      slice_control = 3'h0;
    end
  end

  // Result word with the current slice bit merged in.
  always_comb begin
    out_next_s = out_r;
    if (state_r == RUN) begin
      out_next_s[idx_r] = slice_out;
    end else begin
      out_next_s = out_r;
    end
  end

  // Datapath: operand capture, serial accumulation and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      ctrl_r     <= 3'h0;
      carry_r    <= 1'b0;
      idx_r      <= {IW{1'b0}};
      out_r      <= {WIDTH{1'b0}};
      carryout_r <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      busy_r <= (state_next_s == RUN);
      done_r <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r        <= a;
            b_r        <= b;
            ctrl_r     <= control;
            carry_r    <= (control == 3'h3);
            idx_r      <= {IW{1'b0}};
            out_r      <= {WIDTH{1'b0}};
            carryout_r <= 1'b0;
            overflow_r <= 1'b0;
            err_r      <= illegal_s;
            zero_r     <= illegal_s;
          end else begin
            idx_r <= idx_r;
          end
        end
        RUN: begin
          out_r   <= out_next_s;
          carry_r <= arith_s ? slice_cout : 1'b0;
          if (last_s) begin
            // carry_r here is the carry into the MSB.
            idx_r      <= {IW{1'b0}};
            carryout_r <= arith_s ? slice_cout : 1'b0;
            overflow_r <= arith_s ? (carry_r ^ slice_cout) : 1'b0;
            zero_r     <= (out_next_s == {WIDTH{1'b0}});
          end else begin
            idx_r <= idx_r + IW'(1);
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

endmodule
